// File: rtl/serial_add_ctrl_pkg.sv
// Types shared by the bit-serial adder controller.
package serial_add_ctrl_pkg;
`include "serial_add_defs.vh"

  typedef enum logic [1:0] {
    IDLE = `SA_ST_IDLE,
    RUN  = `SA_ST_RUN,
    DONE = `SA_ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder built from two half adders and an OR.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic ab_sum;
  logic ab_carry;
  logic cin_carry;

  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (ab_sum),
    .carry (ab_carry)
  );

  half_adder u_ha_cin (
    .a     (ab_sum),
    .b     (cin),
    .sum   (sum),
    .carry (cin_carry)
  );

  assign carry = ab_carry | cin_carry;

endmodule

// File: rtl/half_adder.sv
// Combinational 1-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_defs.vh
// Shared FSM state encodings for the bit-serial adder, used by RTL and bench.
`ifndef SERIAL_ADD_DEFS_VH
`define SERIAL_ADD_DEFS_VH

`define SA_ST_IDLE 2'd0
`define SA_ST_RUN  2'd1
`define SA_ST_DONE 2'd2

`endif

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell processes the operands LSB first,
// one bit per clock, under an IDLE/RUN/DONE controller.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_reg, state_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             load, shift;

  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fa_sum, fa_carry;

  full_adder u_fa (
    .a     (a_sh_reg[0]),
    .b     (b_sh_reg[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (cnt_reg == CNT_LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Status flags are registered copies of the state being entered.
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // The sum register is not cleared on load: WIDTH shifts fully replace it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (load) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (shift) begin
      sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
      carry_reg <= fa_carry;
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign sum       = sum_reg;
  assign carry_out = carry_reg;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to add a and b; sampled on rising edge.
REQ-005 a  input  WIDTH  operand A; sampled only when a start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when a start is accepted.
REQ-007 busy  output  1  high while an addition is in progress.
REQ-008 done  output  1  one-cycle pulse: sum/carry_out valid.
REQ-009 sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-010 carry_out  output  1  carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL add the operands bit-serially, LSB first, through one 1-bit full-adder cell (built from two half adders plus an OR), one bit per clock.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE: start=1 at an edge SHALL be accepted. Accepting latches a and b into shift registers, clears the carry flop and bit counter, and moves to RUN.
REQ-014 RUN: each edge SHALL shift one sum bit into the MSB of the sum register, register the cell carry, shift the operands right and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles. The edge that processes bit WIDTH-1 SHALL move to DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: start accepted at edge k -> busy=1 from edge k to edge k+WIDTH -> done=1 from edge k+WIDTH to edge k+WIDTH+1.
REQ-018 busy SHALL be 1 in RUN only. done SHALL be 1 in DONE only. Both SHALL be registered outputs.
REQ-019 sum and carry_out SHALL be stable and correct while done=1, and SHALL hold that value until the next accepted start.
REQ-020 start SHALL be ignored in RUN and DONE. There is no queueing, and operand changes during RUN SHALL NOT affect the result.
REQ-021 start held high continuously SHALL launch a new addition at the first edge in IDLE, giving a period of WIDTH+2 cycles.
REQ-022 Operand and counter width rules:
- Counter width SHALL be clog2(WIDTH+1).
- Counter wrap SHALL NOT occur within one operation.
- The carry-in of bit 0 SHALL be 0.

Reset
REQ-023 rst_n low SHALL immediately, asynchronously, force:
- FSM to IDLE;
- busy=0, done=0, sum=0, carry_out=0;
- internal shift registers, carry flop and counter to 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after release SHALL behave as a fresh operation.
REQ-025 start sampled on the first edge after rst_n deasserts SHALL be accepted.

Structure
REQ-026 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared header serial_add_defs.vh, included by RTL and bench.
REQ-027 The 1-bit adder SHALL be a separate sub-module, full_adder:
- inputs a, b, cin; outputs sum, carry;
- internally two half_adder instances and an OR;
- purely combinational.
REQ-028 serial_add_ctrl SHALL contain exactly one full_adder instance. No other arithmetic on the operands is permitted.

Verification
REQ-029 Basic add: WIDTH=8, a=8'h00, b=8'h00, start pulse -> done at start-edge+8, sum=8'h00, carry_out=0.
REQ-030 Carry chain: a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1; a=8'hA5, b=8'h5A -> sum=8'hFF, carry_out=0.
REQ-031 Busy lockout: start at edge k with a=8'h0F, b=8'h01; start again at k+3 with a=8'hFF, b=8'hFF -> single done at k+8, sum=8'h10, carry_out=0; no second done.
REQ-032 Back-to-back: start held high with constant a=8'h80, b=8'h80 -> done pulses every 10 cycles, each with sum=8'h00, carry_out=1.
REQ-033 Reset mid-op: rst_n low at k+4 of an 8'hFF+8'hFF add -> busy, done, sum and carry_out immediately 0. Then a=8'h03, b=8'h04 after release -> sum=8'h07, carry_out=0.
REQ-034 Random self-check: 1000 random operand pairs at WIDTH=8 and WIDTH=16, checking {carry_out,sum} equals a+b at every done pulse.
